svm_seq_ctrl: RTL
=================

# svm_seq_ctrl

Sequencing controller for the sequential SVM classifier datapath. It time-multiplexes one shared multiply-accumulate unit over all one-vs-rest classifiers: it walks feature and class indices, drives the accumulator clear/enable/bias strobes, and compares each finished class score against a running maximum. It publishes the winning class index with a level `ready` flag. It sits inside `top` between the input feature register and weight/bias ROMs on one side and the `ready`/`w_class` outputs on the other.

## Interface
- `N_features`, 11, features per sample (one MAC cycle each)
- `N_classes`, 6, classifiers evaluated (one-vs-rest)
- `scoreWidth`, 16, width of the signed accumulator score from the datapath
- `featSelWidth`, `$clog2(N_features)`, width of the feature index (localparam)
- `classWidth`, `$clog2(N_classes)`, width of the class index (localparam)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  restart request; honoured only in DONE
- `score`  in  scoreWidth  signed accumulator output (weights·features + bias); registered in the datapath
- `feat_sel`  out  featSelWidth  feature/weight index for the MAC
- `class_sel`  out  classWidth  classifier index selecting the weight and bias ROM row
- `acc_clr`  out  1  clear accumulator on this edge
- `acc_en`  out  1  accumulate `w[class_sel][feat_sel]*x[feat_sel]` on this edge
- `bias_en`  out  1  add `bias[class_sel]` on this edge
- `ready`  out  1  result valid, held high
- `w_class`  out  classWidth  winning class index

## Operation
- All outputs are Moore, decoded from registered state, `feat_sel`, `class_sel` and best-score registers.
- States:
  - IDLE (reset state): all strobes low. Next edge → CLR with class 0 (auto-start after reset).
  - CLR: `acc_clr`=1, `feat_sel`=0 → MAC.
  - MAC: `acc_en`=1. `feat_sel` increments each cycle. On the edge where `feat_sel`==N_features-1 → BIAS.
  - BIAS: `bias_en`=1 → CMP.
  - CMP: samples `score`, which now holds the full class sum.
    - Class 0: always loaded into best_score and best_idx.
    - Class >0: updates best only if `score` > best_score (signed, strict).
    - If `class_sel`==N_classes-1 → DONE. Otherwise increment `class_sel` → CLR.
  - DONE: `ready`=1, `w_class`=best_idx, held indefinitely. `start`=1 → CLR with class 0; best registers are reinitialised by the class-0 CMP.
- Ties keep the lower class index.
- Signed compare over full scoreWidth: 0x8000 is the minimum, 0x7FFF the maximum.
- `start` outside DONE is ignored; it is not queued.
- `w_class` updates only on the edge entering DONE and holds its value through the next run until the next DONE.
- Only one of `acc_clr`/`acc_en`/`bias_en` is high in any cycle.
- Out-of-range `feat_sel`/`class_sel` values are never driven.

## Timing
- Reset (asynchronous, any state): state=IDLE, `feat_sel`=0, `class_sel`=0, `acc_clr`=`acc_en`=`bias_en`=0, `ready`=0, `w_class`=0, best_score=0, best_idx=0. Takes effect immediately, mid-run included.
- Per class: N_features+3 cycles (1 CLR + N_features MAC + 1 BIAS + 1 CMP); 14 at defaults.
- Reset-release latency: `ready` rises on rising edge 1+N_classes·(N_features+3) after `rst_n` deasserts; edge 85 at defaults.
- The class-k CLR state is entered at edge 1+14k.
- Restart latency: the edge sampling `start` in DONE enters CLR, and `ready` falls on that same edge. `ready` rises again N_classes·(N_features+3) edges later (84).
- Datapath contract: the accumulator registers on the edge where its strobe is high, so `score` in CMP reflects the BIAS edge.

## Test plan
- Auto-start, defaults, stub per-class scores {5, −3, 12, 7, 12, 0} → `ready` rises at edge 85, `w_class`=2 (tie with class 4 keeps 2); `ready`/`w_class` stable for 50 further cycles.
- Strobe sequencing monitor → per class exactly one `acc_clr`, 11 consecutive `acc_en` with `feat_sel` 0..10 in order, one `bias_en`, constant `class_sel`; classes visited 0..5; strobes never overlap.
- Signed compare, scores {0x8000 ×6} → `w_class`=0. Scores {−100, −50, −200, 0x8000, −51, −50} → `w_class`=1.
- Last-class winner, scores {0, 1, 2, 3, 4, 0x7FFF} → `w_class`=5.
- Restart: `start` pulse during MAC of class 2 → ignored, result at edge 85. `start` in DONE → `ready` low on that edge, high 84 edges later with the new result; `w_class` holds the old value until then.
- Reset mid-run (`rst_n` low during MAC, class 3, feat 6) → all outputs 0 immediately without waiting for a clock edge. After release, full sequence restarts at class 0 and `ready` rises at edge 85.

Source files
------------

// File: rtl/svm_seq_ctrl.sv
// svm_seq_ctrl: walks class/feature indices for the shared MAC, strobes clear/accumulate/bias,
// and keeps the arg-max class score, publishing it as w_class with a level ready flag.
module svm_seq_ctrl #(
    parameter int N_features   = 11,
    parameter int N_classes    = 6,
    parameter int scoreWidth   = 16,
    localparam int featSelWidth = $clog2(N_features),
    localparam int classWidth   = $clog2(N_classes)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic signed [scoreWidth-1:0] score,
    output logic [featSelWidth-1:0]      feat_sel,
    output logic [classWidth-1:0]        class_sel,
    output logic                         acc_clr,
    output logic                         acc_en,
    output logic                         bias_en,
    output logic                         ready,
    output logic [classWidth-1:0]        w_class
);
    typedef enum logic [2:0] {IDLE, CLR, MAC, BIAS, CMP, DONE} state_t;

    localparam logic [featSelWidth-1:0] FEAT_LAST  = featSelWidth'(N_features - 1);
    localparam logic [classWidth-1:0]   CLASS_LAST = classWidth'(N_classes - 1);

    state_t                         state_q;
    logic [featSelWidth-1:0]        feat_q;
    logic [classWidth-1:0]          class_q, best_idx_q, w_class_q;
    logic signed [scoreWidth-1:0]   best_score_q;
    logic                           acc_clr_q, acc_en_q, bias_en_q, ready_q;
    logic                           take;

    // Class 0 seeds the running best; later classes must strictly beat it, so ties keep the lower index.
    assign take = (class_q == '0) || (score > best_score_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            feat_q       <= '0;
            class_q      <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            w_class_q    <= '0;
            acc_clr_q    <= 1'b0;
            acc_en_q     <= 1'b0;
            bias_en_q    <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            acc_clr_q <= 1'b0;
            acc_en_q  <= 1'b0;
            bias_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q   <= CLR;
                    class_q   <= '0;
                    feat_q    <= '0;
                    acc_clr_q <= 1'b1;
                end
                CLR: begin
                    state_q  <= MAC;
                    acc_en_q <= 1'b1;
                end
                MAC: begin
                    if (feat_q == FEAT_LAST) begin
                        state_q   <= BIAS;
                        bias_en_q <= 1'b1;
                    end else begin
                        feat_q   <= feat_q + 1'b1;
                        acc_en_q <= 1'b1;
                    end
                end
                BIAS: state_q <= CMP;
                CMP: begin
                    if (take) begin
                        best_score_q <= score;
                        best_idx_q   <= class_q;
                    end
                    if (class_q == CLASS_LAST) begin
                        state_q   <= DONE;
                        ready_q   <= 1'b1;
                        w_class_q <= take ? class_q : best_idx_q;
                    end else begin
                        state_q   <= CLR;
                        class_q   <= class_q + 1'b1;
                        feat_q    <= '0;
                        acc_clr_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q   <= CLR;
                        class_q   <= '0;
                        feat_q    <= '0;
                        acc_clr_q <= 1'b1;
                        ready_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign feat_sel  = feat_q;
    assign class_sel = class_q;
    assign acc_clr   = acc_clr_q;
    assign acc_en    = acc_en_q;
    assign bias_en   = bias_en_q;
    assign ready     = ready_q;
    assign w_class   = w_class_q;
endmodule
